// File: rtl/mux_word_scanner.sv
// mux_word_scanner
//   Sequencer wrapped around a 2**IDX_W-to-1 word multiplexer. A single start
//   command (start_idx, count) becomes a burst of (index, word) beats. Each
//   beat is streamed downstream over a valid/ready handshake. The index wraps
//   modulo 2**IDX_W.
//
// Parameters
//   WORD_W  : width of each mux word and of m_data
//   IDX_W   : select/index width
//   MUX_LAT : mux latency from mux_sel to a valid mux_word (0 or 1)
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   start      in   command strobe, only honoured in IDLE
//   start_idx  in   first word index of the burst
//   count      in   number of words in the burst (0 .. 2**IDX_W)
//   abort      in   synchronous cancel of the current burst
//   mux_sel    out  select to the word mux
//   mux_word   in   word returned by the mux
//   m_valid    out  output beat valid
//   m_ready    in   downstream accepts the beat
//   m_data     out  captured word
//   m_idx      out  index the captured word came from
//   busy       out  high in every state except IDLE
//   done       out  one-cycle pulse at burst end
//
// Optional feature
//   SCAN_ZERO_SKIP_EN : when defined, captured words equal to zero are
//   counted but never emitted.

module mux_word_scanner #(
  parameter int WORD_W  = 4,
  parameter int IDX_W   = 8,
  parameter int MUX_LAT = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [IDX_W-1:0]  start_idx,
  input  logic [IDX_W:0]    count,
  input  logic              abort,
  output logic [IDX_W-1:0]  mux_sel,
  input  logic [WORD_W-1:0] mux_word,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [WORD_W-1:0] m_data,
  output logic [IDX_W-1:0]  m_idx,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_EMIT,
    S_DONE
  } state_t;

  state_t            state_q;
  logic [IDX_W-1:0]  idx_q;
  logic [IDX_W-1:0]  idx_d;
  logic [IDX_W:0]    remaining_q;
  logic [IDX_W:0]    remaining_d;
  logic [IDX_W-1:0]  mux_sel_q;
  logic              m_valid_q;
  logic [WORD_W-1:0] m_data_q;
  logic [IDX_W-1:0]  m_idx_q;
  logic              done_q;
  logic              capture;
  logic              skip_word;

  // Index and count values after consuming one word; the index wraps naturally
  // because it is exactly IDX_W bits wide.
  assign idx_d       = idx_q + 1'b1;
  assign remaining_d = remaining_q - 1'b1;

  // The mux word is sampled at the end of ISSUE for a combinational mux and
  // at the end of WAIT for a one-cycle registered mux.
  assign capture = ((state_q == S_ISSUE) && (MUX_LAT == 0)) || (state_q == S_WAIT);

`ifdef SCAN_ZERO_SKIP_EN
  assign skip_word = (mux_word == '0);
`else
  assign skip_word = 1'b0;
`endif

  // Burst sequencer. All outputs are registered here so m_ready never has a
  // combinational path to any output. abort wins over everything else while a
  // burst is active and also suppresses a simultaneous start in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      remaining_q <= '0;
      mux_sel_q   <= '0;
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
      m_idx_q     <= '0;
      done_q      <= 1'b0;
    end else if (abort && (state_q != S_IDLE)) begin
      state_q   <= S_IDLE;
      m_valid_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && !abort) begin
            if (count != '0) begin
              idx_q       <= start_idx;
              remaining_q <= count;
              mux_sel_q   <= start_idx;
              state_q     <= S_ISSUE;
            end else begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end
          end
        end

        S_ISSUE, S_WAIT: begin
          if (capture) begin
            idx_q       <= idx_d;
            remaining_q <= remaining_d;
            if (skip_word) begin
              // A skipped word never reaches EMIT; move straight on.
              if (remaining_d != '0) begin
                mux_sel_q <= idx_d;
                state_q   <= S_ISSUE;
              end else begin
                done_q  <= 1'b1;
                state_q <= S_DONE;
              end
            end else begin
              m_data_q  <= mux_word;
              m_idx_q   <= idx_q;
              m_valid_q <= 1'b1;
              state_q   <= S_EMIT;
            end
          end else begin
            state_q <= S_WAIT;
          end
        end

        S_EMIT: begin
          if (m_ready) begin
            m_valid_q <= 1'b0;
            if (remaining_q != '0) begin
              // idx_q already points at the next word.
              mux_sel_q <= idx_q;
              state_q   <= S_ISSUE;
            end else begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end
          end
        end

        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign mux_sel = mux_sel_q;
  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_idx   = m_idx_q;
  assign done    = done_q;
  assign busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_mux_word_scanner.sv
// tb_mux_word_scanner
//   Drives two scanner instances side by side, one with a combinational mux
//   (MUX_LAT=0) and one with a registered mux (MUX_LAT=1), both reading the
//   same word array. Expected beats come from a list built directly from the
//   burst rules: walk count indices from start_idx modulo 256 and emit each
//   (index, word) pair, dropping zero words when SCAN_ZERO_SKIP_EN is defined.

module tb_mux_word_scanner;

  localparam int WordW = 4;
  localparam int IdxW  = 8;

`ifdef SCAN_ZERO_SKIP_EN
  localparam bit ZeroSkip = 1'b1;
`else
  localparam bit ZeroSkip = 1'b0;
`endif

  typedef struct {
    int sIdx;
    int cnt;
    int expBeats;
    int expLastIdx;
    int expLastData;
  } vec_t;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              abort;
  logic              mReady;
  logic [IdxW-1:0]   startIdx;
  logic [IdxW:0]     count;

  logic [IdxW-1:0]   muxSel0, mIdx0, muxSel1, mIdx1;
  logic [WordW-1:0]  muxWord0, mData0, muxWord1, mData1;
  logic              mValid0, busy0, done0;
  logic              mValid1, busy1, done1;

  logic [WordW-1:0]  memArr [256];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [11:0] got0[$];
  logic [11:0] got1[$];
  logic [11:0] expQ[$];
  int          beatCyc0[$];
  int          beatCyc1[$];
  int          doneCnt0 = 0;
  int          doneCnt1 = 0;
  int          base0, base1, doneBase0, doneBase1;
  bit          randReady;
  vec_t        vecs[7];

  mux_word_scanner #(.WORD_W(WordW), .IDX_W(IdxW), .MUX_LAT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .start_idx(startIdx),
    .count(count), .abort(abort), .mux_sel(muxSel0), .mux_word(muxWord0),
    .m_valid(mValid0), .m_ready(mReady), .m_data(mData0), .m_idx(mIdx0),
    .busy(busy0), .done(done0)
  );

  mux_word_scanner #(.WORD_W(WordW), .IDX_W(IdxW), .MUX_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .start_idx(startIdx),
    .count(count), .abort(abort), .mux_sel(muxSel1), .mux_word(muxWord1),
    .m_valid(mValid1), .m_ready(mReady), .m_data(mData1), .m_idx(mIdx1),
    .busy(busy1), .done(done1)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word arrays: combinational for dut0, one-cycle registered for dut1
  assign muxWord0 = memArr[muxSel0];
  always @(posedge clk) muxWord1 <= memArr[muxSel1];

  // Cycle stamp used for beat spacing
  always @(posedge clk) cyc <= cyc + 1;

  // Beat and done monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (rst_n) begin
      if (mValid0 && mReady && !abort) begin
        got0.push_back({mIdx0, mData0});
        beatCyc0.push_back(cyc);
      end
      if (mValid1 && mReady && !abort) begin
        got1.push_back({mIdx1, mData1});
        beatCyc1.push_back(cyc);
      end
      if (done0) doneCnt0 = doneCnt0 + 1;
      if (done1) doneCnt1 = doneCnt1 + 1;
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic markScore();
    base0     = got0.size();
    base1     = got1.size();
    doneBase0 = doneCnt0;
    doneBase1 = doneCnt1;
  endtask

  task automatic applyStimulus(input int s, input int c);
    startIdx = 8'(s);
    count    = 9'(c);
    start    = 1'b1;
    stepCycle();
    start    = 1'b0;
  endtask

  task automatic waitIdle(input int limit);
    int n = 0;
    while ((busy0 || busy1) && n < limit) begin
      if (randReady) mReady = 1'($urandom_range(0, 1));
      stepCycle();
      n++;
    end
    checkOutput("idle_wait_timeout", {63'd0, (busy0 || busy1)}, 64'd0);
    mReady = 1'b1;
    stepCycle();
    stepCycle();
  endtask

  // Reference burst: every index from s, c words, modulo 256
  task automatic buildExpected(input int s, input int c);
    int i;
    expQ.delete();
    for (int k = 0; k < c; k++) begin
      i = (s + k) % 256;
      if (!(ZeroSkip && memArr[i] == '0)) expQ.push_back({i[7:0], memArr[i]});
    end
  endtask

  task automatic checkBeats(input string name);
    int n0   = got0.size() - base0;
    int n1   = got1.size() - base1;
    int bad0 = -1;
    int bad1 = -1;
    checkOutput({name, "_count0"}, n0, expQ.size());
    checkOutput({name, "_count1"}, n1, expQ.size());
    for (int k = 0; k < expQ.size() && k < n0; k++)
      if (bad0 < 0 && got0[base0 + k] !== expQ[k]) bad0 = k;
    for (int k = 0; k < expQ.size() && k < n1; k++)
      if (bad1 < 0 && got1[base1 + k] !== expQ[k]) bad1 = k;
    checkOutput({name, "_firstbad0"}, bad0, -1);
    checkOutput({name, "_firstbad1"}, bad1, -1);
  endtask

  task automatic checkDoneOnce(input string name);
    checkOutput({name, "_done0"}, doneCnt0 - doneBase0, 1);
    checkOutput({name, "_done1"}, doneCnt1 - doneBase1, 1);
  endtask

  initial begin
    // Zero-free fill: f(i) = i%15 + 1
    vecs[0] = '{3,   4,   4,   6,  7};
    vecs[1] = '{254, 4,   4,   1,  2};
    vecs[2] = '{250, 10,  10,  3,  4};
    vecs[3] = '{0,   1,   1,   0,  1};
    vecs[4] = '{255, 2,   2,   0,  1};
    vecs[5] = '{100, 256, 256, 99, 10};
    vecs[6] = '{7,   0,   0,   0,  0};

    rst_n     = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    mReady    = 1'b1;
    startIdx  = '0;
    count     = '0;
    randReady = 1'b0;
    for (int i = 0; i < 256; i++) memArr[i] = 4'(i % 16);

    // Reset state
    stepCycle();
    stepCycle();
    checkOutput("reset_dut0", {muxSel0, mValid0, mData0, mIdx0, busy0, done0}, 0);
    checkOutput("reset_dut1", {muxSel1, mValid1, mData1, mIdx1, busy1, done1}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    stepCycle();

    // Latency and throughput, word[i] = i%16
    markScore();
    applyStimulus(3, 4);
    checkOutput("lat_sel_t1", muxSel0, 3);
    checkOutput("lat_valid_t1", mValid0, 0);
    stepCycle();
    checkOutput("lat_beat_t2", {mValid0, mIdx0, mData0}, {1'b1, 8'd3, 4'd3});
    for (int k = 1; k < 4; k++) begin
      stepCycle();
      checkOutput("thr_issue", {mValid0, muxSel0}, {1'b0, 8'(3 + k)});
      stepCycle();
      checkOutput("thr_beat", {mValid0, mIdx0, mData0}, {1'b1, 8'(3 + k), 4'(3 + k)});
    end
    stepCycle();
    checkOutput("done_pulse", {done0, busy0}, 2'b11);
    stepCycle();
    checkOutput("done_end", {done0, busy0}, 2'b00);
    waitIdle(200);
    buildExpected(3, 4);
    checkBeats("seq_basic");
    checkDoneOnce("seq_basic");
    for (int k = 1; k < 4; k++) begin
      checkOutput("spacing_lat0", beatCyc0[base0 + k] - beatCyc0[base0 + k - 1], 2);
      checkOutput("spacing_lat1", beatCyc1[base1 + k] - beatCyc1[base1 + k - 1], 3);
    end

    // Back-pressure on the first beat
    markScore();
    mReady = 1'b0;
    applyStimulus(20, 3);
    stepCycle();
    for (int k = 0; k < 5; k++) begin
      checkOutput("stall_hold", {mValid0, mIdx0, mData0, muxSel0},
                  {1'b1, 8'd20, 4'd4, 8'd20});
      stepCycle();
    end
    mReady = 1'b1;
    waitIdle(200);
    buildExpected(20, 3);
    checkBeats("stall");
    checkDoneOnce("stall");

    // count = 0
    markScore();
    applyStimulus(7, 0);
    checkOutput("cnt0_done", {done0, busy0, mValid0, done1, busy1}, 5'b11011);
    stepCycle();
    checkOutput("cnt0_idle", {done0, busy0, done1, busy1}, 4'b0000);
    waitIdle(20);
    buildExpected(7, 0);
    checkBeats("cnt0");
    checkDoneOnce("cnt0");

    // start while busy is ignored
    markScore();
    applyStimulus(5, 3);
    stepCycle();
    startIdx = 8'd100;
    count    = 9'd256;
    start    = 1'b1;
    stepCycle();
    start    = 1'b0;
    waitIdle(400);
    buildExpected(5, 3);
    checkBeats("ignore_start");
    checkDoneOnce("ignore_start");

    // abort in EMIT together with m_ready
    markScore();
    applyStimulus(40, 5);
    stepCycle();
    checkOutput("abort_pre_valid", mValid0, 1);
    abort = 1'b1;
    stepCycle();
    abort = 1'b0;
    checkOutput("abort_idle", {mValid0, busy0, done0, busy1, mValid1}, 0);
    repeat (4) stepCycle();
    checkOutput("abort_no_beats", (got0.size() - base0) + (got1.size() - base1), 0);
    checkOutput("abort_no_done", (doneCnt0 - doneBase0) + (doneCnt1 - doneBase1), 0);

    // Asynchronous reset mid-burst
    applyStimulus(60, 5);
    stepCycle();
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_reset_dut0", {muxSel0, mValid0, mData0, mIdx0, busy0, done0}, 0);
    checkOutput("async_reset_dut1", {muxSel1, mValid1, mData1, mIdx1, busy1, done1}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    stepCycle();
    checkOutput("post_reset_idle", {busy0, busy1, mValid0, mValid1}, 0);

    // Zero words inside a burst
    memArr[10] = 4'd5;
    memArr[11] = 4'd0;
    memArr[12] = 4'd0;
    memArr[13] = 4'd7;
    markScore();
    applyStimulus(10, 4);
    waitIdle(100);
    buildExpected(10, 4);
    checkBeats("zero_words");
    checkDoneOnce("zero_words");

    // Table-driven bursts on a zero-free array
    for (int i = 0; i < 256; i++) memArr[i] = 4'((i % 15) + 1);
    for (int v = 0; v < 7; v++) begin
      markScore();
      applyStimulus(vecs[v].sIdx, vecs[v].cnt);
      waitIdle(1500);
      checkOutput("vec_beats0", got0.size() - base0, vecs[v].expBeats);
      checkOutput("vec_beats1", got1.size() - base1, vecs[v].expBeats);
      if (vecs[v].expBeats > 0) begin
        checkOutput("vec_last0", got0[got0.size() - 1],
                    {8'(vecs[v].expLastIdx), 4'(vecs[v].expLastData)});
        checkOutput("vec_last1", got1[got1.size() - 1],
                    {8'(vecs[v].expLastIdx), 4'(vecs[v].expLastData)});
      end
      buildExpected(vecs[v].sIdx, vecs[v].cnt);
      checkBeats("vec");
      checkDoneOnce("vec");
    end

    // Randomized bursts with random back-pressure
    for (int r = 0; r < 20; r++) begin
      int s;
      int c;
      for (int i = 0; i < 256; i++) memArr[i] = 4'($urandom_range(0, 15));
      s = $urandom_range(0, 255);
      c = $urandom_range(0, 40);
      markScore();
      randReady = 1'b1;
      applyStimulus(s, c);
      waitIdle(3000);
      randReady = 1'b0;
      buildExpected(s, c);
      checkBeats("rand");
      checkDoneOnce("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
